// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the instruction-fetch stage.
//   - PCSRC_*     : next-PC select encodings driven by the core
//   - NOP_INSTR   : canonical RISC-V NOP (addi x0, x0, 0)
//   - fetch_state_t : fetch FSM state encoding
package riscv_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_HOLD,
        FETCH_TRAP
    } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC computation.
// Ports:
//   pc        in  32  current PC
//   extimm    in  32  sign-extended immediate (used unmodified)
//   aluresult in  32  JALR target
//   pcsrc     in   2  next-PC select (11 behaves as PC+4)
//   pcplus4   out 32  pc + 4
//   pctarget  out 32  pc + extimm
//   next_pc   out 32  selected next PC
//   misaligned out 1  next_pc is not word aligned
module pc_next_mux
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] extimm,
    input  logic [31:0] aluresult,
    input  logic [1:0]  pcsrc,
    output logic [31:0] pcplus4,
    output logic [31:0] pctarget,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    assign pcplus4  = pc + 32'd4;
    assign pctarget = pc + extimm;

    always_comb begin
        next_pc = pcplus4;
        case (pcsrc)
            PCSRC_BRANCH: next_pc = pctarget;
            // JALR clears bit0 of the computed target, as the ISA requires
            PCSRC_JALR:   next_pc = {aluresult[31:1], 1'b0};
            default:      next_pc = pcplus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage. Holds the PC, requests words from
// instruction memory, latches the response and updates the PC on retire.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   imem_req/imem_addr    fetch request toward instruction memory
//   imem_rvalid/imem_rdata response from instruction memory
//   instr_valid/instr     latched instruction and its valid flag
//   imm                   instr[31:7] toward the immediate extender
//   extimm                extended immediate back from the extender
//   aluresult             JALR target
//   pcsrc                 next-PC select
//   retire, stall         instruction consumed / retirement blocked
//   pc, pcplus4, pctarget PC and derived addresses
//   misalign              sticky misaligned-target trap flag
module pc_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [24:0] imm,
    input  logic [31:0] extimm,
    input  logic [31:0] aluresult,
    input  logic [1:0]  pcsrc,
    input  logic        retire,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] pctarget,
    output logic        misalign
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] next_pc;
    logic        next_misaligned;
    logic        capture;
    logic        accept;

    pc_next_mux u_pc_next_mux (
        .pc         (pc),
        .extimm     (extimm),
        .aluresult  (aluresult),
        .pcsrc      (pcsrc),
        .pcplus4    (pcplus4),
        .pctarget   (pctarget),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    // rvalid and retire are only honoured in their own states
    assign capture = (state == FETCH_REQ) && imem_rvalid;
    assign accept  = (state == FETCH_HOLD) && retire && !stall;

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH_IDLE: state_next = FETCH_REQ;
            FETCH_REQ: begin
                imem_req = 1'b1;
                if (imem_rvalid) state_next = FETCH_HOLD;
            end
            FETCH_HOLD: begin
                instr_valid = 1'b1;
                if (accept) state_next = next_misaligned ? FETCH_TRAP : FETCH_REQ;
            end
            FETCH_TRAP: state_next = FETCH_TRAP;
            default:    state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            instr    <= NOP_INSTR;
            misalign <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) instr <= imem_rdata;
            if (accept) begin
                // a misaligned target traps without disturbing pc
                if (next_misaligned) misalign <= 1'b1;
                else                 pc       <= next_pc;
            end
        end
    end

    assign imem_addr = pc;
    assign imm       = instr[31:7];

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch with a scoreboard of
// expected instructions and expected PCs.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [24:0] imm;
    logic [31:0] extimm;
    logic [31:0] aluresult;
    logic [1:0]  pcsrc;
    logic        retire;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] pctarget;
    logic        misalign;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .imm         (imm),
        .extimm      (extimm),
        .aluresult   (aluresult),
        .pcsrc       (pcsrc),
        .retire      (retire),
        .stall       (stall),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .pctarget    (pctarget),
        .misalign    (misalign)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] model_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                              input logic [31:0] ext, input logic [31:0] alu);
        logic [31:0] r;
        case (src)
            2'b01:   r = cur + ext;
            2'b10:   r = alu & 32'hFFFF_FFFE;
            default: r = cur + 32'd4;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        check("rst_pc",       pc,                  RST_PC);
        check("rst_instr",    instr,               32'h0000_0013);
        check("rst_valid",    {31'b0, instr_valid}, 32'd0);
        check("rst_req",      {31'b0, imem_req},    32'd0);
        check("rst_misalign", {31'b0, misalign},    32'd0);
        reset = 1'b0;
        model_pc = RST_PC;
        exp_instr_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("req_seen", {31'b0, imem_req}, 32'd1);
    endtask

    // Memory responder: answers the current request after lat idle cycles.
    task automatic fetch(input logic [31:0] word, input int lat);
        logic [31:0] e;
        wait_req();
        check("fetch_addr", imem_addr, model_pc);
        for (int i = 0; i < lat; i++) begin
            step();
            check("req_held",  {31'b0, imem_req},    32'd1);
            check("valid_low", {31'b0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        exp_instr_q.push_back(word);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("instr_valid", {31'b0, instr_valid}, 32'd1);
        check("req_drop",    {31'b0, imem_req},    32'd0);
        if (exp_instr_q.size() == 0) begin
            check("instr_sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_instr_q.pop_front();
            check("instr", instr, e);
            check("imm",   {7'b0, imm}, {7'b0, e[31:7]});
        end
    endtask

    task automatic retire_op(input logic [1:0] src, input logic [31:0] ext,
                             input logic [31:0] alu, input int stall_cycles);
        logic [31:0] nxt;
        logic [31:0] e;
        nxt = ref_next(model_pc, src, ext, alu);
        pcsrc     = src;
        extimm    = ext;
        aluresult = alu;
        retire    = 1'b1;
        stall     = (stall_cycles > 0);
        #1;
        check("pcplus4",  pcplus4,  model_pc + 32'd4);
        check("pctarget", pctarget, model_pc + ext);
        for (int i = 0; i < stall_cycles; i++) begin
            step();
            check("stall_pc",    pc,                   model_pc);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        if (nxt[1:0] == 2'b00) exp_pc_q.push_back(nxt);
        step();
        retire = 1'b0;
        if (nxt[1:0] == 2'b00) begin
            check("retire_req", {31'b0, imem_req}, 32'd1);
            e = exp_pc_q.pop_front();
            check("retire_pc",   pc,        e);
            check("retire_addr", imem_addr, e);
            check("no_trap",     {31'b0, misalign}, 32'd0);
            model_pc = e;
        end else begin
            check("trap_misalign", {31'b0, misalign},    32'd1);
            check("trap_pc",       pc,                   model_pc);
            check("trap_req",      {31'b0, imem_req},    32'd0);
            check("trap_valid",    {31'b0, instr_valid}, 32'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        extimm      = '0;
        aluresult   = '0;
        pcsrc       = 2'b00;
        retire      = 1'b0;
        stall       = 1'b0;
        step();
        do_reset();

        // First request one cycle after reset release
        step();
        check("first_req",  {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RST_PC);

        fetch(32'h0050_0093, 0);
        retire_op(2'b00, 32'h0, 32'h0, 0);                   // 0x104

        // 3-cycle memory, then spurious rvalid in HOLD
        fetch(32'h0010_8113, 3);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("spurious_instr", instr, 32'h0010_8113);
        check("spurious_valid", {31'b0, instr_valid}, 32'd1);

        retire_op(2'b10, 32'h0, 32'h0000_0201, 4);           // stall 4, then 0x200
        fetch(32'hFE00_0EE3, 1);
        retire_op(2'b01, 32'hFFFF_FFF0, 32'h0, 0);           // 0x1F0
        fetch(32'h0000_0013, 0);
        retire_op(2'b10, 32'h0, 32'h0000_0305, 0);           // 0x304
        fetch(32'h1234_5067, 2);
        retire_op(2'b10, 32'h0, 32'hFFFF_FFFC, 0);           // 0xFFFFFFFC
        fetch(32'h0000_0013, 0);
        retire_op(2'b00, 32'h0, 32'h0, 1);                   // wraps to 0x0
        fetch(32'h0000_0013, 0);
        retire_op(2'b11, 32'h0, 32'hFFFF_FFFF, 0);           // reserved -> 0x4
        fetch(32'h0000_0013, 0);
        retire_op(2'b10, 32'h0, 32'h0000_0001, 0);           // 0x0
        fetch(32'h0020_006F, 0);
        retire_op(2'b01, 32'h0000_0002, 32'h0, 0);           // traps

        // TRAP ignores everything but reset
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'b1;
            retire      = 1'b1;
            step();
            check("trap_hold_mis", {31'b0, misalign}, 32'd1);
            check("trap_hold_req", {31'b0, imem_req}, 32'd0);
            check("trap_hold_pc",  pc, 32'd0);
        end
        imem_rvalid = 1'b0;
        retire      = 1'b0;

        // Reset leaves TRAP; then reset in REQ with a response due
        do_reset();
        fetch(32'h0000_0093, 0);
        retire_op(2'b00, 32'h0, 32'h0, 0);                   // 0x104, in REQ
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        step();
        imem_rvalid = 1'b0;
        check("abort_pc",    pc,    RST_PC);
        check("abort_instr", instr, 32'h0000_0013);
        check("abort_valid", {31'b0, instr_valid}, 32'd0);
        check("abort_mis",   {31'b0, misalign},    32'd0);
        reset    = 1'b0;
        model_pc = RST_PC;
        fetch(32'h0030_0193, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
